// File: rtl/bus2reg_arbiter_pkg.sv
// Shared types and default widths for the bus2reg arbiter.
package bus2reg_arb_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_ADDR_WIDTH     = 11;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT,
        S_RESP  = ST_RESP
    } arb_state_e;

endpackage

// File: rtl/bus2reg_arbiter_rr.sv
// Combinational round-robin pick: first set request strictly after ptr_i, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    int  idx;
    logic found;

    always_comb begin
        gnt_o = '0;
        idx   = 0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr_i) + k) % NUM_REQ;
            if (!found && req_i[IDX_W'(idx)]) begin
                gnt_o[IDX_W'(idx)] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus2reg_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ requesters onto one register-map bus.
// Optional WAIT timeout is compiled in with BUS2REG_ARB_TIMEOUT_EN.
//   state | meaning
//   IDLE  | no owner, arbitrating among s_req
//   ISSUE | one-cycle bus_req with the owner's registered fields
//   WAIT  | holding bus fields until bus_ready (or timeout)
//   RESP  | one-cycle s_ready to the owner with registered data/error
module bus2reg_arbiter
    import bus2reg_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            s_req,
    input  logic [NUM_REQ-1:0]            s_req_is_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_wr_data,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_wr_biten,
    output logic [NUM_REQ-1:0]            s_ready,
    output logic                          s_err,
    output logic [DATA_WIDTH-1:0]         s_rd_data,
    output logic                          bus_req,
    output logic                          bus_req_is_wr,
    output logic [ADDR_WIDTH-1:0]         bus_addr,
    output logic [DATA_WIDTH-1:0]         bus_wr_data,
    output logic [DATA_WIDTH-1:0]         bus_wr_biten,
    output logic                          bus_req_stall_wr,
    output logic                          bus_req_stall_rd,
    input  logic                          bus_ready,
    input  logic                          bus_err,
    input  logic [DATA_WIDTH-1:0]         bus_rd_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("bus2reg_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_e            state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic                  is_wr_q, is_wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] biten_q, biten_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [ADDR_WIDTH-1:0] req_addr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] req_wdata [NUM_REQ];
    logic [DATA_WIDTH-1:0] req_biten [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_addr[g]  = s_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign req_wdata[g] = s_wr_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign req_biten[g] = s_wr_biten[g*DATA_WIDTH +: DATA_WIDTH];
    end

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i (s_req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                arb_idx = IDX_W'(i);
            end
        end
    end

    assign arb_any = |arb_gnt;

`ifdef BUS2REG_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout;

    // cnt_q counts completed ISSUE/WAIT cycles; the last allowed one hits TIMEOUT_CYCLES-1.
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        is_wr_d = is_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        biten_d = biten_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef BUS2REG_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    owner_d = arb_idx;
                    ptr_d   = arb_idx;
                    is_wr_d = s_req_is_wr[arb_idx];
                    addr_d  = req_addr[arb_idx];
                    wdata_d = req_wdata[arb_idx];
                    biten_d = req_biten[arb_idx];
                    state_d = S_ISSUE;
`ifdef BUS2REG_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_ISSUE, S_WAIT: begin
`ifdef BUS2REG_ARB_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (bus_ready) begin
                    rdata_d = is_wr_q ? '0 : bus_rd_data;
                    err_d   = bus_err;
                    state_d = S_RESP;
                end
`ifdef BUS2REG_ARB_TIMEOUT_EN
                else if (timeout) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
`endif
                else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            owner_q <= '0;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            biten_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            biten_q <= biten_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

`ifdef BUS2REG_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    logic [NUM_REQ-1:0] owner_oh;
    logic               in_resp;

    assign owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
    assign in_resp  = (state_q == S_RESP);

    assign busy             = (state_q != S_IDLE);
    assign grant            = busy ? owner_oh : '0;
    assign bus_req          = (state_q == S_ISSUE);
    assign bus_req_is_wr    = is_wr_q;
    assign bus_addr         = addr_q;
    assign bus_wr_data      = wdata_q;
    assign bus_wr_biten     = biten_q;
    assign bus_req_stall_wr = 1'b0;
    assign bus_req_stall_rd = 1'b0;

    // Response fields are forced to 0 outside RESP so stale data never leaks out.
    assign s_ready   = in_resp ? owner_oh : '0;
    assign s_err     = in_resp & err_q;
    assign s_rd_data = in_resp ? rdata_q : '0;

endmodule

// File: tb/tb_bus2reg_arbiter.sv
// Self-checking bench for bus2reg_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level model.
module tb_bus2reg_arbiter;

    localparam int NR = 2;
    localparam int DW = 32;
    localparam int AW = 11;
`ifdef BUS2REG_ARB_TIMEOUT_EN
    localparam int TO    = 8;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 64;
    localparam bit TO_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [NR-1:0]      s_req, s_req_is_wr;
    logic [NR*AW-1:0]   s_addr;
    logic [NR*DW-1:0]   s_wr_data, s_wr_biten;
    logic [NR-1:0]      s_ready;
    logic               s_err;
    logic [DW-1:0]      s_rd_data;
    logic               bus_req, bus_req_is_wr;
    logic [AW-1:0]      bus_addr;
    logic [DW-1:0]      bus_wr_data, bus_wr_biten;
    logic               bus_req_stall_wr, bus_req_stall_rd;
    logic               bus_ready, bus_err;
    logic [DW-1:0]      bus_rd_data;
    logic [NR-1:0]      grant;
    logic               busy;

    bus2reg_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_req(s_req), .s_req_is_wr(s_req_is_wr), .s_addr(s_addr),
        .s_wr_data(s_wr_data), .s_wr_biten(s_wr_biten),
        .s_ready(s_ready), .s_err(s_err), .s_rd_data(s_rd_data),
        .bus_req(bus_req), .bus_req_is_wr(bus_req_is_wr), .bus_addr(bus_addr),
        .bus_wr_data(bus_wr_data), .bus_wr_biten(bus_wr_biten),
        .bus_req_stall_wr(bus_req_stall_wr), .bus_req_stall_rd(bus_req_stall_rd),
        .bus_ready(bus_ready), .bus_err(bus_err), .bus_rd_data(bus_rd_data),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Transaction-level model: one owner at a time, ready one cycle after bus_ready.
    bit            m_busy, m_resp, m_wr, m_err;
    int            m_owner, m_t, m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_biten, m_rd;

    always @(posedge clk or negedge rst) begin
        int  cand;
        bit  found;
        if (!rst) begin
            m_busy = 0; m_resp = 0; m_last = NR - 1; m_owner = 0; m_t = 0;
        end else if (m_resp) begin
            m_resp = 0;
            m_busy = 0;
        end else if (m_busy) begin
            if (bus_ready) begin
                m_resp = 1;
                m_rd   = m_wr ? '0 : bus_rd_data;
                m_err  = bus_err;
            end else if (TO_EN && (m_t == TO - 1)) begin
                m_resp = 1;
                m_rd   = '0;
                m_err  = 1;
            end else begin
                m_t++;
            end
        end else begin
            found = 0;
            for (int k = 1; k <= NR; k++) begin
                cand = (m_last + k) % NR;
                if (!found && s_req[cand]) begin
                    found   = 1;
                    m_owner = cand;
                    m_last  = cand;
                    m_wr    = s_req_is_wr[cand];
                    m_addr  = s_addr[cand*AW +: AW];
                    m_wdata = s_wr_data[cand*DW +: DW];
                    m_biten = s_wr_biten[cand*DW +: DW];
                    m_busy  = 1;
                    m_t     = 0;
                end
            end
        end
    end

    task automatic compare_model();
        logic [NR-1:0] oh;
        oh = NR'(1) << m_owner;
        chk("grant",   grant,   m_busy ? oh : '0);
        chk("busy",    busy,    m_busy);
        chk("bus_req", bus_req, m_busy && !m_resp && m_t == 0);
        chk("s_ready", s_ready, m_resp ? oh : '0);
        chk("s_err",   s_err,   m_resp ? m_err : 1'b0);
        chk("s_rd_data", s_rd_data, m_resp ? m_rd : '0);
        chk("stall", {bus_req_stall_wr, bus_req_stall_rd}, 2'b00);
        if (m_busy && !m_resp) begin
            chk("bus_is_wr", bus_req_is_wr, m_wr);
            chk("bus_addr",  bus_addr,  m_addr);
            chk("bus_wdata", bus_wr_data, m_wdata);
            chk("bus_biten", bus_wr_biten, m_biten);
        end
    endtask

    bit auto_en = 0;
    bit sl_active = 0;
    int sl_cnt = 0;

    task automatic drive_auto();
        for (int i = 0; i < NR; i++) begin
            if (s_ready[i]) begin
                s_req[i] = 1'b0;
            end else if (!s_req[i] && $urandom_range(3) == 0) begin
                s_req[i]               = 1'b1;
                s_req_is_wr[i]         = 1'($urandom_range(1));
                s_addr[i*AW +: AW]     = AW'($urandom);
                s_wr_data[i*DW +: DW]  = $urandom;
                s_wr_biten[i*DW +: DW] = $urandom;
            end else if (s_req[i] && $urandom_range(63) == 0) begin
                s_req[i] = 1'b0;
            end
        end
        if (|s_ready) sl_active = 0;
        if (bus_req) begin
            sl_active = 1;
            sl_cnt    = $urandom_range(TO_EN ? 12 : 6);
        end
        if (sl_active) begin
            bus_ready = (sl_cnt == 0);
            bus_err   = 1'($urandom_range(1));
            if (sl_cnt == 0) sl_active = 0;
            else sl_cnt--;
        end else begin
            bus_ready = ($urandom_range(3) == 0);
            bus_err   = 1'($urandom_range(1));
        end
        bus_rd_data = $urandom;
    endtask

    task automatic tick();
        @(negedge clk);
        compare_model();
        if (auto_en) drive_auto();
    endtask

    task automatic wait_bus_req(input int lim);
        int n;
        n = 0;
        while (bus_req !== 1'b1 && n < lim) begin
            tick();
            n++;
        end
        chk("bus_req_seen", bus_req, 1'b1);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {grant, busy, bus_req, s_ready, s_err, s_rd_data, bus_req_is_wr,
                   bus_addr, bus_wr_data, bus_wr_biten, bus_req_stall_wr, bus_req_stall_rd}, '0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        s_req = '0;
        bus_ready = 1'b0;
        tick();
        tick();
        chk_all_zero("reset_outputs");
        rst = 1'b1;
        tick();
    endtask

    logic [NR-1:0] order [4];
    int            n_tx, n_cyc;

    initial begin
        rst = 1'b0;
        s_req = '0; s_req_is_wr = '0; s_addr = '0; s_wr_data = '0; s_wr_biten = '0;
        bus_ready = 1'b0; bus_err = 1'b0; bus_rd_data = '0;
        do_reset();

        // Single read, ready in ISSUE.
        s_req = 2'b01; s_req_is_wr = 2'b00; s_addr[AW-1:0] = 11'h010;
        tick();
        chk("t1_bus_req", bus_req, 1'b1);
        chk("t1_addr", bus_addr, 11'h010);
        chk("t1_grant", grant, 2'b01);
        bus_ready = 1'b1; bus_rd_data = 32'hDEADBEEF; bus_err = 1'b0;
        tick();
        chk("t1_s_ready", s_ready, 2'b01);
        chk("t1_rd_data", s_rd_data, 32'hDEADBEEF);
        chk("t1_s_err", s_err, 1'b0);
        s_req = '0; bus_ready = 1'b0;
        tick();

        // Contention from reset.
        do_reset();
        s_req = 2'b11;
        n_tx = 0; n_cyc = 0;
        while (n_tx < 4 && n_cyc < 20) begin
            tick();
            n_cyc++;
            bus_ready = 1'b0;
            if (bus_req) begin
                order[n_tx] = grant;
                n_tx++;
                bus_ready = 1'b1;
            end
        end
        chk("t2_count", n_tx, 4);
        chk("t2_order", {order[0], order[1], order[2], order[3]}, 8'b01_10_01_10);
        s_req = '0;
        tick();
        bus_ready = 1'b0;
        tick();
        tick();

        // Slow slave: write from requester 1, ready 5 cycles after ISSUE with error.
        s_req = 2'b10; s_req_is_wr = 2'b10;
        s_addr[AW +: AW] = 11'h155;
        s_wr_data[DW +: DW] = 32'h12345678;
        s_wr_biten[DW +: DW] = 32'hFFFF0000;
        wait_bus_req(5);
        for (int k = 0; k < 6; k++) begin
            chk("t3_addr", bus_addr, 11'h155);
            chk("t3_wdata", bus_wr_data, 32'h12345678);
            chk("t3_biten", bus_wr_biten, 32'hFFFF0000);
            chk("t3_is_wr", bus_req_is_wr, 1'b1);
            chk("t3_grant", grant, 2'b10);
            bus_ready = (k == 5);
            bus_err = (k == 5);
            bus_rd_data = 32'hA5A5A5A5;
            tick();
        end
        chk("t3_s_ready", s_ready, 2'b10);
        chk("t3_s_err", s_err, 1'b1);
        chk("t3_rd_zero", s_rd_data, 32'h0);
        s_req = '0; bus_ready = 1'b0; bus_err = 1'b0;
        tick();

        // Reset while in WAIT.
        s_req = 2'b01; s_req_is_wr = 2'b00; s_addr[AW-1:0] = 11'h020;
        wait_bus_req(5);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_all_zero("t4_rst_out0");
        tick();
        chk_all_zero("t4_rst_out1");
        rst = 1'b1;
        s_req = 2'b11;
        wait_bus_req(5);
        chk("t4_first_grant", grant, 2'b01);
        bus_ready = 1'b1; bus_rd_data = 32'h0BADF00D;
        tick();
        chk("t4_s_ready", s_ready, 2'b01);
        chk("t4_rd_data", s_rd_data, 32'h0BADF00D);
        s_req = '0; bus_ready = 1'b0;
        tick();
        tick();

`ifdef BUS2REG_ARB_TIMEOUT_EN
        // Timeout with no bus_ready, then a stray ready.
        s_req = 2'b01; s_req_is_wr = 2'b00;
        wait_bus_req(5);
        n_cyc = 0;
        while (s_ready == '0 && n_cyc < 40) begin
            tick();
            n_cyc++;
        end
        chk("t5_latency", n_cyc, TO);
        chk("t5_s_err", s_err, 1'b1);
        chk("t5_rd_zero", s_rd_data, 32'h0);
        s_req = '0; bus_ready = 1'b1; bus_rd_data = 32'hFFFFFFFF;
        tick();
        chk("t5_stray_busy", busy, 1'b0);
        chk("t5_stray_ready", s_ready, 2'b00);
        tick();
        chk("t5_stray_busy2", busy, 1'b0);
        bus_ready = 1'b0;
        tick();
`endif

        // Random traffic.
        auto_en = 1;
        repeat (3000) tick();
        auto_en = 0;
        s_req = '0;
        bus_ready = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus2reg_arbiter.md
BUS2REG_ARBITER -- requirements
Module: bus2reg_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data and bit-enable width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 11: register address width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64: WAIT-state limit when the timeout feature is compiled in.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port s_req, input, NUM_REQ: per-requester request, held high until that requester's s_ready.
REQ-008 SHALL have port s_req_is_wr, input, NUM_REQ: per-requester write (1) or read (0).
REQ-009 SHALL have port s_addr, input, NUM_REQ*ADDR_WIDTH: packed per-requester address; requester i occupies slice i.
REQ-010 SHALL have port s_wr_data, input, NUM_REQ*DATA_WIDTH: packed per-requester write data.
REQ-011 SHALL have port s_wr_biten, input, NUM_REQ*DATA_WIDTH: packed per-requester bit enables.
REQ-012 SHALL have port s_ready, output, NUM_REQ: one-cycle completion pulse to the granted requester.
REQ-013 SHALL have port s_err, output, 1: error flag, valid only while s_ready is set.
REQ-014 SHALL have port s_rd_data, output, DATA_WIDTH: read data, valid only while s_ready is set.
REQ-015 SHALL have ports bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten, outputs: the register-map request side.
REQ-016 SHALL have ports bus_req_stall_wr and bus_req_stall_rd, outputs, 1: both tied to 0.
REQ-017 SHALL have ports bus_ready, bus_err, bus_rd_data, inputs: the register-map response side.
REQ-018 SHALL have port grant, output, NUM_REQ: one-hot owner while not IDLE, otherwise 0.
REQ-019 SHALL have port busy, output, 1: high when state is not IDLE.

Function
REQ-020 SHALL implement a four-state FSM: IDLE, ISSUE, WAIT, RESP.
REQ-021 IDLE: if any s_req is set, the arbiter SHALL pick a winner round-robin, register its request fields, and go to ISSUE; otherwise it stays in IDLE.
REQ-022 Round-robin: search starts at the index after the last granted requester, wrapping NUM_REQ-1 -> 0; the pointer SHALL update only on a grant.
REQ-023 ISSUE: bus_req SHALL be high for exactly one cycle, with the registered fields.
REQ-024 If bus_ready is high in ISSUE, the arbiter SHALL go to RESP; otherwise it goes to WAIT.
REQ-025 WAIT: on bus_ready, the arbiter SHALL capture bus_rd_data and bus_err and go to RESP.
REQ-026 RESP: s_ready[owner] SHALL be high for one cycle, with s_rd_data and s_err registered; the next state is IDLE.
REQ-027 Latency: s_req to bus_req is 1 cycle, and bus_ready to s_ready is 1 cycle; minimum transaction time is 3 cycles.
REQ-028 bus_addr, bus_wr_data and bus_wr_biten SHALL stay stable from ISSUE until leaving WAIT.
REQ-029 A bus_ready in IDLE or RESP SHALL be ignored.
REQ-030 Changes on s_req of non-owners SHALL NOT affect the transaction in flight.
REQ-031 s_rd_data SHALL be 0 for writes.
REQ-032 If the owner drops s_req mid-transaction (protocol violation), the transaction SHALL still complete.

Reset
REQ-033 When rst is low, the block SHALL immediately set state to IDLE and the round-robin pointer to NUM_REQ-1, so requester 0 wins first.
REQ-034 When rst is low, all outputs SHALL be 0.
REQ-035 Reset mid-transaction SHALL drop the transaction and produce no s_ready.

Configuration
REQ-036 With macro BUS2REG_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to ISSUE and increment each cycle in ISSUE and WAIT.
REQ-037 When that counter reaches TIMEOUT_CYCLES without bus_ready, the arbiter SHALL go to RESP with s_err=1 and s_rd_data=0.
REQ-038 With BUS2REG_ARB_TIMEOUT_EN undefined, WAIT SHALL persist indefinitely and no counter logic is present.

Structure
REQ-039 Package bus2reg_arb_pkg SHALL hold the FSM state enum and the default DATA_WIDTH, ADDR_WIDTH and TIMEOUT_CYCLES constants.
REQ-040 Sub-module rr_arbiter SHALL compute the combinational one-hot grant from the request vector and the pointer.

Verification
REQ-041 Single read: s_req[0] with addr 0x010 and bus_ready in ISSUE returning 0xDEADBEEF -> bus_req asserted 1 cycle after s_req, s_ready[0] 2 cycles after s_req, s_rd_data=0xDEADBEEF, s_err=0.
REQ-042 Contention: s_req=2'b11 held after reset -> grant order 0, 1, 0, 1, with exactly one bus_req per transaction.
REQ-043 Slow slave: bus_ready delayed 5 cycles with bus_err=1 -> bus fields stable for 6 cycles, then s_ready[1] with s_err=1.
REQ-044 Timeout (macro defined, TIMEOUT_CYCLES=8): bus_ready never asserted -> s_ready with s_err=1 and s_rd_data=0; a later stray bus_ready is ignored.
REQ-045 Reset in WAIT: rst low for 2 cycles -> all outputs 0, no s_ready, and the next grant goes to requester 0.
